// File: rtl/rggen_avalon_pipeline_slice_pkg.sv
// Shared Avalon response codes and the register-slice FSM encoding.
package rggen_avalon_pipeline_slice_pkg;

  localparam logic [1:0] RGGEN_AVALON_OKAY        = 2'b00;
  localparam logic [1:0] RGGEN_AVALON_RESERVED    = 2'b01;
  localparam logic [1:0] RGGEN_AVALON_SLAVEERROR  = 2'b10;
  localparam logic [1:0] RGGEN_AVALON_DECODEERROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } slice_state_e;

endpackage

// File: rtl/rggen_avalon_pipeline_slice.sv
// Avalon-MM register slice: command registered to o_m_* one edge after the request,
// response registered one edge after downstream accept; one transfer in flight, upstream stalled via waitrequest.
module rggen_avalon_pipeline_slice
  import rggen_avalon_pipeline_slice_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
)(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_s_read,
  input  logic                     i_s_write,
  input  logic [ADDRESS_WIDTH-1:0] i_s_address,
  input  logic [BUS_WIDTH/8-1:0]   i_s_byteenable,
  input  logic [BUS_WIDTH-1:0]     i_s_writedata,
  output logic                     o_s_waitrequest,
  output logic [1:0]               o_s_response,
  output logic [BUS_WIDTH-1:0]     o_s_readdata,
  output logic                     o_m_read,
  output logic                     o_m_write,
  output logic [ADDRESS_WIDTH-1:0] o_m_address,
  output logic [BUS_WIDTH/8-1:0]   o_m_byteenable,
  output logic [BUS_WIDTH-1:0]     o_m_writedata,
  input  logic                     i_m_waitrequest,
  input  logic [1:0]               i_m_response,
  input  logic [BUS_WIDTH-1:0]     i_m_readdata
);

  slice_state_e state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      o_m_read        <= 1'b0;
      o_m_write       <= 1'b0;
      o_m_address     <= '0;
      o_m_byteenable  <= '0;
      o_m_writedata   <= '0;
      o_s_waitrequest <= 1'b1;
      o_s_response    <= RGGEN_AVALON_OKAY;
      o_s_readdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_s_read || i_s_write) begin
            state          <= BUSY;
            // A simultaneous read and write is treated as a write only.
            o_m_read       <= i_s_read && !i_s_write;
            o_m_write      <= i_s_write;
            o_m_address    <= i_s_address;
            o_m_byteenable <= i_s_byteenable;
            o_m_writedata  <= i_s_writedata;
          end
        end
        BUSY: begin
          if (!i_m_waitrequest) begin
            state           <= RESPOND;
            o_m_read        <= 1'b0;
            o_m_write       <= 1'b0;
            o_s_waitrequest <= 1'b0;
            o_s_response    <= i_m_response;
            o_s_readdata    <= o_m_read ? i_m_readdata : '0;
          end
        end
        RESPOND: begin
          state           <= IDLE;
          o_s_waitrequest <= 1'b1;
        end
        default: begin
          state           <= IDLE;
          o_m_read        <= 1'b0;
          o_m_write       <= 1'b0;
          o_s_waitrequest <= 1'b1;
        end
      endcase
    end
  end

endmodule
